// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with bounded tenure and one-hot select
//
// Purpose:
//   Owns the select lines of the shared tri-state datapath bus. At most one
//   driver is selected per cycle. A hold limit bounds how long an owner keeps
//   the bus while others wait. Handoff between owners is back-to-back.
//
// Ports:
//   clk          rising-edge system clock
//   reset        synchronous, active-high reset
//   req          request vector, bit i = driver i wants the bus
//   sel_lines    registered one-hot (or zero) select vector
//   grant_valid  registered, high when sel_lines has a bit set
//   grant_id     registered binary index of the selected driver, 0 when idle
//   bus_busy     grant_valid && req[grant_id]

module bus_arbiter #(
  parameter int Bus_length = 32,
  parameter int Max_hold   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [Bus_length-1:0]         req,
  output logic [Bus_length-1:0]         sel_lines,
  output logic                          grant_valid,
  output logic [$clog2(Bus_length)-1:0] grant_id,
  output logic                          bus_busy
);

  localparam int IDW = $clog2(Bus_length);
  localparam int HW  = $clog2(Max_hold) + 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(Max_hold - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(Bus_length - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [HW-1:0]   hold_cnt;

  logic [Bus_length-1:0] cand;
  logic                  any_cand;
  logic                  found;
  logic [IDW-1:0]        win;
  int                    idx;

  // Candidates never include the current owner: in IDLE sel_lines is zero so
  // this is plain req, in OWNED every new grant must go to someone else.
  always_comb begin
    cand     = req & ~sel_lines;
    any_cand = |cand;
    found    = 1'b0;
    win      = '0;
    idx      = 0;
    for (int i = 0; i < Bus_length; i++) begin
      idx = int'(ptr) + i;
      if (idx >= Bus_length) idx = idx - Bus_length;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      sel_lines   <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_cand) begin
            state       <= OWNED;
            sel_lines   <= Bus_length'(1) << win;
            grant_valid <= 1'b1;
            grant_id    <= win;
            ptr         <= (win == LAST_ID) ? '0 : win + 1'b1;
            hold_cnt    <= '0;
          end
        end
        OWNED: begin
          // Owner released, or owner exhausted its tenure with someone waiting:
          // hand off directly to the next candidate.
          if ((!req[grant_id] || hold_cnt == HOLD_LAST) && any_cand) begin
            sel_lines   <= Bus_length'(1) << win;
            grant_valid <= 1'b1;
            grant_id    <= win;
            ptr         <= (win == LAST_ID) ? '0 : win + 1'b1;
            hold_cnt    <= '0;
          end else if (!req[grant_id]) begin
            state       <= IDLE;
            sel_lines   <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            hold_cnt    <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            // Nobody else is waiting: renew tenure, ptr stays put.
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_busy = grant_valid & req[grant_id];

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter

module tb_bus_arbiter;

  localparam int N  = 32;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  sel_lines;
  logic          grant_valid;
  logic [4:0]    grant_id;
  logic          bus_busy;

  int errors = 0;
  int checks = 0;

  // reference model: who owns the bus, where the next scan starts, how many
  // cycles of the current tenure have elapsed
  int m_owner = -1;
  int m_ptr   = 0;
  int m_ten   = 0;

  bus_arbiter #(.Bus_length(N), .Max_hold(MH)) dut (
    .clk(clk), .reset(reset), .req(req), .sel_lines(sel_lines),
    .grant_valid(grant_valid), .grant_id(grant_id), .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int i = 0; i < N; i++) begin
      if (r[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  function automatic void model_edge(input logic [N-1:0] r, input logic rst);
    logic [N-1:0] others;
    int w;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_ten = 0;
      return;
    end
    others = r;
    if (m_owner >= 0) others[m_owner] = 1'b0;
    w = pick(others, m_ptr);
    if (m_owner < 0 || !r[m_owner] || m_ten == MH - 1) begin
      if (w >= 0) begin
        m_owner = w; m_ptr = (w + 1) % N; m_ten = 0;
      end else if (m_owner >= 0 && r[m_owner]) begin
        m_ten = 0;
      end else begin
        m_owner = -1; m_ten = 0;
      end
    end else begin
      m_ten++;
    end
  endfunction

  // drive at negedge, advance model at posedge, settle for sampling
  task automatic cycle(input logic [N-1:0] r, input logic rst);
    @(negedge clk);
    req = r;
    reset = rst;
    @(posedge clk);
    model_edge(r, rst);
    #1;
  endtask

  task automatic test_reset();
    cycle('1, 1'b1);
    cycle('1, 1'b1);
    checks++; if (sel_lines !== '0) begin errors++; $display("FAIL reset_sel got=%h exp=0", sel_lines); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", grant_valid); end
    checks++; if (grant_id !== 5'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", grant_id); end
    checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus_busy); end
    cycle('1, 1'b0);
    checks++; if (sel_lines !== 32'h1) begin errors++; $display("FAIL reset_first_grant got=%h exp=00000001", sel_lines); end
    checks++; if (grant_id !== 5'd0 || grant_valid !== 1'b1) begin errors++; $display("FAIL reset_first_id got=%0d/%b exp=0/1", grant_id, grant_valid); end
  endtask

  task automatic test_single();
    cycle('0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cycle(32'h1 << 7, 1'b0);
      checks++;
      if (sel_lines !== (32'h1 << 7) || grant_id !== 5'd7 || bus_busy !== 1'b1)
        begin errors++; $display("FAIL single_hold cyc=%0d got sel=%h id=%0d busy=%b exp sel=00000080 id=7 busy=1", k, sel_lines, grant_id, bus_busy); end
    end
    cycle('0, 1'b0);
    checks++;
    if (sel_lines !== '0 || grant_valid !== 1'b0)
      begin errors++; $display("FAIL single_release got sel=%h valid=%b exp 0/0", sel_lines, grant_valid); end
  endtask

  task automatic test_round_robin();
    int order[3] = '{0, 5, 31};
    logic [N-1:0] all3;
    logic [N-1:0] r;
    all3 = (32'h1 << 0) | (32'h1 << 5) | (32'h1 << 31);
    cycle('0, 1'b1);
    r = all3;
    for (int k = 0; k < 9; k++) begin
      cycle(r, 1'b0);
      checks++;
      if (grant_valid !== 1'b1 || grant_id !== 5'(order[k % 3]))
        begin errors++; $display("FAIL rr_order step=%0d got id=%0d valid=%b exp id=%0d valid=1", k, grant_id, grant_valid, order[k % 3]); end
      r = all3 & ~(32'h1 << order[k % 3]);
    end
  endtask

  task automatic test_preempt();
    logic [N-1:0] r;
    int w3 = 0, w9 = 0, max3 = 0, max9 = 0;
    r = (32'h1 << 3) | (32'h1 << 9);
    cycle('0, 1'b1);
    for (int k = 1; k <= 24; k++) begin
      cycle(r, 1'b0);
      checks++;
      if (grant_id !== ((((k - 1) / MH) % 2 == 0) ? 5'd3 : 5'd9))
        begin errors++; $display("FAIL preempt_owner cyc=%0d got=%0d exp=%0d", k, grant_id, ((((k - 1) / MH) % 2 == 0) ? 3 : 9)); end
      w3 = sel_lines[3] ? 0 : w3 + 1;
      w9 = sel_lines[9] ? 0 : w9 + 1;
      if (w3 > max3) max3 = w3;
      if (w9 > max9) max9 = w9;
    end
    checks++; if (max3 > 5) begin errors++; $display("FAIL preempt_wait3 got=%0d exp<=5", max3); end
    checks++; if (max9 > 5) begin errors++; $display("FAIL preempt_wait9 got=%0d exp<=5", max9); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] r;
    r = (32'h1 << 12) | (32'h1 << 20);
    cycle('0, 1'b1);
    cycle(r, 1'b0);
    cycle(r, 1'b0);
    checks++; if (grant_id !== 5'd12) begin errors++; $display("FAIL midreset_owner got=%0d exp=12", grant_id); end
    cycle(r, 1'b1);
    checks++; if (sel_lines !== '0 || grant_valid !== 1'b0) begin errors++; $display("FAIL midreset_clear got sel=%h valid=%b exp 0/0", sel_lines, grant_valid); end
    cycle(r, 1'b0);
    checks++; if (grant_id !== 5'd12 || sel_lines !== (32'h1 << 12)) begin errors++; $display("FAIL midreset_regrant got id=%0d sel=%h exp 12", grant_id, sel_lines); end
  endtask

  task automatic test_random();
    logic [N-1:0] r = '0;
    logic [N-1:0] exp_sel;
    logic rst;
    int wait_c[N];
    int worst;
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    cycle('0, 1'b1);
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) r[i] = ~r[i];
      rst = ($urandom_range(499) == 0);
      cycle(r, rst);
      exp_sel = (m_owner < 0) ? '0 : (32'h1 << m_owner);
      checks++;
      if (sel_lines !== exp_sel || grant_valid !== (m_owner >= 0) ||
          grant_id !== ((m_owner < 0) ? 5'd0 : 5'(m_owner)) ||
          bus_busy !== ((m_owner >= 0) && r[m_owner]))
        begin errors++; $display("FAIL rand_model cyc=%0d got sel=%h v=%b id=%0d busy=%b exp sel=%h owner=%0d", k, sel_lines, grant_valid, grant_id, bus_busy, exp_sel, m_owner); end
      checks++;
      if ($countones(sel_lines) > 1 || (grant_valid && sel_lines !== (32'h1 << grant_id)))
        begin errors++; $display("FAIL rand_onehot cyc=%0d got sel=%h id=%0d exp one-hot matching id", k, sel_lines, grant_id); end
      worst = 0;
      for (int i = 0; i < N; i++) begin
        wait_c[i] = (rst || !r[i] || sel_lines[i]) ? 0 : wait_c[i] + 1;
        if (wait_c[i] > worst) worst = wait_c[i];
      end
      checks++;
      if (worst > (N - 1) * MH + 1)
        begin errors++; $display("FAIL rand_wait cyc=%0d got=%0d exp<=%0d", k, worst, (N - 1) * MH + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that owns the select lines of the shared tri-state datapath bus. It accepts up to `Bus_length` request lines from bus drivers (register file ports, ALU, memory, immediate unit). It issues a registered, strictly one-hot `sel_lines` vector, so at most one driver is enabled per cycle. A programmable hold limit bounds tenure, which prevents starvation while back-to-back handoff keeps the bus busy without idle gaps.

## Interface
- `Bus_length`, 32: number of requesters; equals the bus's driver count; must be ≥ 2.
- `Max_hold`, 4: maximum consecutive cycles an owner keeps the bus while another requester waits; ≥ 1.
- `clk`  input  1  single system clock, rising-edge.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  Bus_length  request vector; bit i high = driver i wants the bus.
- `sel_lines`  output  Bus_length  registered one-hot (or all-zero) select vector; drives the bus select input directly.
- `grant_valid`  output  1  high when any bit of `sel_lines` is set.
- `grant_id`  output  $clog2(Bus_length)  binary index of the set bit; 0 when `grant_valid` = 0.
- `bus_busy`  output  1  high when `grant_valid` and `req[grant_id]` are both high (owner actively using the bus).

## Operation
- Reset (sampled at rising edge with `reset` = 1): `sel_lines` = 0, `grant_valid` = 0, `grant_id` = 0, `bus_busy` = 0. Internal state: `ptr` = 0, `hold_cnt` = 0, state IDLE. `reset` overrides every other input.
- **States:** IDLE (no owner) and OWNED (one owner).
- **Winner selection:** combinational. Scan `req` starting at index `ptr`, ascending, wrapping from Bus_length-1 to 0. The winner is the first set bit.
- **IDLE:**
  - If any `req` is set, go to OWNED with the winner registered into `sel_lines`/`grant_id`.
  - On every grant, `ptr` ← (winner+1) mod Bus_length and `hold_cnt` ← 0.
- **OWNED**, evaluated each edge with owner o:
  - `req[o]` = 0 and other requests present: grant the winner (scan excludes o). No idle cycle.
  - `req[o]` = 0 and no other requests: go to IDLE; `sel_lines` ← 0.
  - `req[o]` = 1 and `hold_cnt` = Max_hold-1 and another requester present: preempt. Grant the winner (excluding o); o must re-request and wait its turn.
  - `req[o]` = 1 and `hold_cnt` = Max_hold-1 and no other requester: keep o; `hold_cnt` ← 0 (tenure renewed).
  - Otherwise: keep o; `hold_cnt` ← `hold_cnt`+1.
- **Ptr rule:** `ptr` updates only on a new grant, never on renewal.
- **Invariant:** `popcount(sel_lines)` ≤ 1 in every cycle, including the cycle after reset and all handoffs. A violation is bus contention and is a hard failure.
- `hold_cnt` width is $clog2(Max_hold)+1; it never exceeds Max_hold-1.

## Timing
- Request-to-grant latency from IDLE: 1 cycle. `req` set before edge N gives `sel_lines` valid after edge N.
- Handoff: the owner drops `req` in cycle C. `sel_lines` still shows the owner in C (`bus_busy` = 0), and the new owner appears after edge C. Drivers must not depend on data sampled in that cycle.
- Preemption: an owner granted at edge G with contention present loses the bus at edge G+Max_hold. It holds for exactly Max_hold cycles.
- Worst-case wait for a continuously requesting driver: (Bus_length-1)·Max_hold + 1 cycles.
- All outputs are registered or derived only from registered state, except `bus_busy`, which also uses `req`. There are no combinational paths from `req` to `sel_lines`.
- Reset asserted mid-tenure: outputs clear after that edge. The first grant after reset deasserts follows the IDLE rule with `ptr` = 0.

## Test plan
- **Reset:** hold `reset` 2 cycles with `req` = all ones -> `sel_lines` = 0, `grant_valid` = 0, `grant_id` = 0. The first edge after release grants id 0.
- **Single requester:** `req[7]` = 1 for 10 cycles, then 0 -> grant id 7 one cycle after request, kept all 10 cycles (renewals every 4), `sel_lines` = 0 one edge after release.
- **Round-robin with wrap-around:** `req` bits 0, 5, 31 held, each dropping after 1 cycle of ownership and re-raising -> grant order 0, 5, 31, 0, 5, … with no idle cycles between grants.
- **Preemption (Max_hold = 4):** `req[3]` and `req[9]` both held -> id 3 owns 4 cycles, id 9 owns 4 cycles, alternating. The wait never exceeds 5 cycles.
- **Reset mid-tenure:** pulse `reset` while id 12 owns with `req[12]`, `req[20]` high -> `sel_lines` = 0 next edge. After release, id 12 is granted (`ptr` = 0 scan).
- **Random traffic:** 10k cycles of random `req` -> `popcount(sel_lines)` ≤ 1 every cycle, `grant_id` consistent with `sel_lines`, and no requester waits beyond 125 cycles (Bus_length = 32, Max_hold = 4).
